// File: rtl/ecore_pkg.sv
// ecore_pkg: shared constants, state encoding and lane helpers for the ecore
// data-bus responder and its GPIO bank.
//   - access size encodings
//   - region base constants and GPIO register offsets
//   - responder FSM state enum
//   - helpers for byte-lane masks, store replication and load extension
package ecore_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic [1:0] SZ_ILL  = 2'd3;

  localparam logic [3:0]  RAM_BASE_NIB = 4'h0;
  localparam logic [31:0] GPIO_BASE    = 32'h4000_0000;

  // Register offsets within the GPIO window (addr[3:0]).
  localparam logic [3:0] GPIO_OUT = 4'h0;
  localparam logic [3:0] GPIO_DIR = 4'h4;
  localparam logic [3:0] GPIO_IN  = 4'h8;

  typedef enum logic [1:0] {
    DB_IDLE     = 2'd0,
    DB_RAM_WAIT = 2'd1,
    DB_RESP     = 2'd2
  } db_state_e;

  // Byte write enables for a store of the given size at byte lane 'lane'.
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lane);
    logic [3:0] m;
    m = 4'b0000;
    case (size)
      SZ_BYTE: m = 4'b0001 << lane;
      SZ_HALF: m = 4'b0011 << lane;
      SZ_WORD: m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  // Right-aligned store data copied onto every lane it could land on, so the
  // byte enables alone select the destination.
  function automatic logic [31:0] wdata_replicate(input logic [1:0] size, input logic [31:0] d);
    logic [31:0] r;
    r = 32'h0000_0000;
    case (size)
      SZ_BYTE: r = {4{d[7:0]}};
      SZ_HALF: r = {2{d[15:0]}};
      SZ_WORD: r = d;
      default: r = 32'h0000_0000;
    endcase
    return r;
  endfunction

  // Mask a right-aligned load value to its size and sign/zero extend it.
  function automatic logic [31:0] load_extend(input logic [31:0] d, input logic [1:0] size,
                                              input logic is_unsigned);
    logic [31:0] r;
    r = 32'h0000_0000;
    case (size)
      SZ_BYTE: r = is_unsigned ? {24'h00_0000, d[7:0]} : {{24{d[7]}}, d[7:0]};
      SZ_HALF: r = is_unsigned ? {16'h0000, d[15:0]} : {{16{d[15]}}, d[15:0]};
      SZ_WORD: r = d;
      default: r = 32'h0000_0000;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ecore_gpio_bank.sv
// ecore_gpio_bank: GPIO register file behind the data-bus responder.
//   OUT (offset 0x0, r/w), DIR (offset 0x4, r/w, 1 = drive pin), IN (offset 0x8,
//   read-only, writes ignored). Pin i is driven with OUT[i] when DIR[i] = 1,
//   otherwise released to high-Z.
//   Macro ECORE_GPIO_SYNC_EN: when defined, IN goes through a 2-flop
//   synchronizer (2-cycle visibility); otherwise a single sampling flop.
// Ports:
//   i_clk, i_rst     clock, asynchronous active-low reset
//   i_wr_en          write strobe (one cycle, word access)
//   i_off [3:0]      register offset (addr[3:0])
//   i_wdata [31:0]   write data
//   o_rdata [31:0]   read data of the addressed register (combinational)
//   io_gpio_bank     GPIO pins
module ecore_gpio_bank
  import ecore_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_wr_en,
  input  logic [3:0]  i_off,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  inout  wire  [31:0] io_gpio_bank
);

  logic [31:0] out_r;
  logic [31:0] dir_r;
  logic [31:0] in_val_s;

  // OUT/DIR register writes; writes to IN or other offsets fall through.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      out_r <= 32'h0000_0000;
      dir_r <= 32'h0000_0000;
    end else if (i_wr_en) begin
      case (i_off)
        GPIO_OUT: out_r <= i_wdata;
        GPIO_DIR: dir_r <= i_wdata;
        default: begin
          out_r <= out_r;
          dir_r <= dir_r;
        end
      endcase
    end else begin
      out_r <= out_r;
      dir_r <= dir_r;
    end
  end

  for (genvar i = 0; i < 32; i++) begin : g_pin
    assign io_gpio_bank[i] = dir_r[i] ? out_r[i] : 1'bz;
  end

`ifdef ECORE_GPIO_SYNC_EN
  logic [31:0] in_s1_r;
  logic [31:0] in_s2_r;

  // Two-stage synchronizer for asynchronous pin inputs.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      in_s1_r <= 32'h0000_0000;
      in_s2_r <= 32'h0000_0000;
    end else begin
      in_s1_r <= io_gpio_bank;
      in_s2_r <= in_s1_r;
    end
  end

  assign in_val_s = in_s2_r;
`else
  logic [31:0] in_s1_r;

  // Single sampling flop; pins are assumed synchronous to i_clk.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      in_s1_r <= 32'h0000_0000;
    end else begin
      in_s1_r <= io_gpio_bank;
    end
  end

  assign in_val_s = in_s1_r;
`endif

  // Read mux for the addressed register.
  always_comb begin
    o_rdata = 32'h0000_0000;
    case (i_off)
      GPIO_OUT: o_rdata = out_r;
      GPIO_DIR: o_rdata = dir_r;
      GPIO_IN:  o_rdata = in_val_s;
      default:  o_rdata = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/ecore_dbus_responder.sv
// ecore_dbus_responder: target-side data-bus responder for the ecore CPU.
//   Accepts one load/store at a time over a valid/ready request channel and
//   returns the result over a valid/ready response channel. Decodes the byte
//   address into RAM (addr[31:28] = 0), a GPIO register window at 0x4000_0000
//   and unmapped space; handles sub-word lanes, sign extension and errors.
//   Macro ECORE_GPIO_SYNC_EN selects the 2-flop GPIO input synchronizer.
// Ports:
//   i_clk, i_rst                     clock, asynchronous active-low reset
//   i_req_valid / o_req_ready        request handshake
//   i_req_we, i_req_size, i_req_unsigned, i_req_addr, i_req_wdata  request fields
//   o_rsp_valid / i_rsp_ready        response handshake
//   o_rsp_rdata, o_rsp_err           response fields (held until accepted)
//   o_ram_en, o_ram_we, o_ram_addr, o_ram_wdata, i_ram_rdata  RAM macro port
//   io_gpio_bank                     GPIO pins
module ecore_dbus_responder
  import ecore_pkg::*;
#(
  parameter int RAM_WORDS     = 1024,
  parameter int RAM_WORDS_LOG = 10
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_req_valid,
  output logic                     o_req_ready,
  input  logic                     i_req_we,
  input  logic [1:0]               i_req_size,
  input  logic                     i_req_unsigned,
  input  logic [31:0]              i_req_addr,
  input  logic [31:0]              i_req_wdata,
  output logic                     o_rsp_valid,
  input  logic                     i_rsp_ready,
  output logic [31:0]              o_rsp_rdata,
  output logic                     o_rsp_err,
  output logic                     o_ram_en,
  output logic [3:0]               o_ram_we,
  output logic [RAM_WORDS_LOG-1:0] o_ram_addr,
  output logic [31:0]              o_ram_wdata,
  input  logic [31:0]              i_ram_rdata,
  inout  wire  [31:0]              io_gpio_bank
);

  db_state_e   state_r;
  db_state_e   state_nxt_s;

  logic        accept_s;
  logic        is_ram_s;
  logic        is_gpio_s;
  logic        misal_s;
  logic        err_s;
  logic        gpio_wr_s;
  logic [31:0] gpio_rdata_s;

  logic [1:0]  size_r;
  logic [1:0]  lane_r;
  logic        unsigned_r;
  logic [31:0] rdata_r;
  logic        err_r;

  // Address decode and error classification of the presented request.
  always_comb begin
    is_ram_s  = (i_req_addr[31:28] == RAM_BASE_NIB);
    is_gpio_s = (i_req_addr[31:4] == GPIO_BASE[31:4]) &&
                ((i_req_addr[3:0] == GPIO_OUT) || (i_req_addr[3:0] == GPIO_DIR) ||
                 (i_req_addr[3:0] == GPIO_IN));
    misal_s   = ((i_req_size == SZ_HALF) && i_req_addr[0]) ||
                ((i_req_size == SZ_WORD) && (i_req_addr[1:0] != 2'b00));
    err_s     = (i_req_size == SZ_ILL) || misal_s || !(is_ram_s || is_gpio_s) ||
                (is_gpio_s && (i_req_size != SZ_WORD));
  end

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_r <= DB_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic; only RAM loads need the extra read cycle.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      DB_IDLE: begin
        if (i_req_valid) begin
          if (is_ram_s && !err_s && !i_req_we) begin
            state_nxt_s = DB_RAM_WAIT;
          end else begin
            state_nxt_s = DB_RESP;
          end
        end else begin
          state_nxt_s = DB_IDLE;
        end
      end
      DB_RAM_WAIT: state_nxt_s = DB_RESP;
      DB_RESP: begin
        if (i_rsp_ready) begin
          state_nxt_s = DB_IDLE;
        end else begin
          state_nxt_s = DB_RESP;
        end
      end
      default: state_nxt_s = DB_IDLE;
    endcase
  end

  // FSM outputs; RAM strobes and GPIO writes only in the accept cycle.
  always_comb begin
    o_req_ready = (state_r == DB_IDLE);
    o_rsp_valid = (state_r == DB_RESP);
    accept_s    = i_req_valid && (state_r == DB_IDLE);
    if (accept_s && !err_s && is_ram_s) begin
      o_ram_en = 1'b1;
      o_ram_we = i_req_we ? lane_mask(i_req_size, i_req_addr[1:0]) : 4'b0000;
    end else begin
      o_ram_en = 1'b0;
      o_ram_we = 4'b0000;
    end
    if (accept_s && !err_s && is_gpio_s && i_req_we) begin
      gpio_wr_s = 1'b1;
    end else begin
      gpio_wr_s = 1'b0;
    end
  end

  assign o_ram_addr  = i_req_addr[2 +: RAM_WORDS_LOG];
  assign o_ram_wdata = wdata_replicate(i_req_size, i_req_wdata);

  // Response datapath: filled at accept, or at the RAM read cycle for loads.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      rdata_r    <= 32'h0000_0000;
      err_r      <= 1'b0;
      size_r     <= SZ_BYTE;
      lane_r     <= 2'b00;
      unsigned_r <= 1'b0;
    end else if (accept_s) begin
      size_r     <= i_req_size;
      lane_r     <= i_req_addr[1:0];
      unsigned_r <= i_req_unsigned;
      err_r      <= err_s;
      if (!err_s && is_gpio_s && !i_req_we) begin
        rdata_r <= gpio_rdata_s;
      end else begin
        rdata_r <= 32'h0000_0000;
      end
    end else if (state_r == DB_RAM_WAIT) begin
      rdata_r <= load_extend(i_ram_rdata >> {lane_r, 3'b000}, size_r, unsigned_r);
      err_r   <= 1'b0;
    end else begin
      rdata_r <= rdata_r;
      err_r   <= err_r;
    end
  end

  assign o_rsp_rdata = rdata_r;
  assign o_rsp_err   = err_r;

  ecore_gpio_bank u_gpio (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_wr_en      (gpio_wr_s),
    .i_off        (i_req_addr[3:0]),
    .i_wdata      (i_req_wdata),
    .o_rdata      (gpio_rdata_s),
    .io_gpio_bank (io_gpio_bank)
  );

endmodule

// File: tb/tb_ecore_dbus_responder.sv
module tb_ecore_dbus_responder;

  logic        clk;
  logic        i_rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_uns;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        ram_en;
  logic [3:0]  ram_we;
  logic [9:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_q;
  wire  [31:0] gpio_w;
  logic [31:0] ext_en;
  logic [31:0] ext_val;

  int total;
  int bad;

  logic [31:0] ram_mem [0:1023];
  logic [7:0]  ref_mem [0:4095];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar i = 0; i < 32; i++) begin : g_ext
    assign gpio_w[i] = ext_en[i] ? ext_val[i] : 1'bz;
  end

  ecore_dbus_responder dut (
    .i_clk(clk), .i_rst(i_rst),
    .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_we(req_we),
    .i_req_size(req_size), .i_req_unsigned(req_uns), .i_req_addr(req_addr),
    .i_req_wdata(req_wdata),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_rdata(rsp_rdata),
    .o_rsp_err(rsp_err),
    .o_ram_en(ram_en), .o_ram_we(ram_we), .o_ram_addr(ram_addr),
    .o_ram_wdata(ram_wdata), .i_ram_rdata(ram_q),
    .io_gpio_bank(gpio_w)
  );

  // External single-port RAM macro: byte-enabled write, registered read.
  always @(posedge clk) begin
    if (ram_en) begin
      for (int k = 0; k < 4; k++) begin
        if (ram_we[k]) ram_mem[ram_addr][8*k +: 8] <= ram_wdata[8*k +: 8];
      end
      ram_q <= ram_mem[ram_addr];
    end
  end

  // Reference: byte-addressed memory plus the address-map/error rules.
  function automatic void ref_access(input logic we, input logic [1:0] sz, input logic uns,
                                     input logic [31:0] addr, input logic [31:0] wd,
                                     output logic [31:0] rd, output logic er,
                                     output logic en, output logic [3:0] wm,
                                     output logic [31:0] wlanes);
    int nb;
    int base;
    logic is_ram;
    logic is_gpio;
    longint v;
    logic [3:0] top;
    nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    top = addr[31:28];
    is_ram = (top == 4'h0);
    is_gpio = (addr == 32'h4000_0000) || (addr == 32'h4000_0004) || (addr == 32'h4000_0008);
    er = (sz == 2'd3) || ((addr % nb) != 0) || !(is_ram || is_gpio) || (is_gpio && sz != 2'd2);
    rd = 32'h0; en = 1'b0; wm = 4'h0; wlanes = 32'h0;
    if (!er && is_ram) begin
      en = 1'b1;
      base = int'(addr % 4096);
      if (we) begin
        for (int k = 0; k < nb; k++) begin
          ref_mem[base + k] = wd[8*k +: 8];
          wm[(base % 4) + k] = 1'b1;
          wlanes[8*((base % 4) + k) +: 8] = wd[8*k +: 8];
        end
      end else begin
        v = 0;
        for (int k = 0; k < nb; k++) v = v + (longint'(ref_mem[base + k]) << (8*k));
        if (!uns && v >= (longint'(1) << (8*nb - 1))) v = v - (longint'(1) << (8*nb));
        rd = v[31:0];
      end
    end
  endfunction

  function automatic logic [31:0] lane_bits(input logic [3:0] m);
    logic [31:0] r;
    for (int k = 0; k < 4; k++) r[8*k +: 8] = m[k] ? 8'hFF : 8'h00;
    return r;
  endfunction

  // One request/response transaction with the response port ready.
  task automatic xfer(input logic we, input logic [1:0] sz, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wd,
                      output logic [31:0] rd, output logic er, output int lat,
                      output logic en_a, output logic [3:0] we_a,
                      output logic [9:0] addr_a, output logic [31:0] wd_a,
                      output logic en_extra);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = sz; req_uns = uns;
    req_addr = addr; req_wdata = wd;
    #1;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk); #1; n++;
    end
    if (!req_ready) begin
      total++; bad++;
      $display("FAIL accept_timeout got=%0b exp=1", req_ready);
    end
    en_a = ram_en; we_a = ram_we; addr_a = ram_addr; wd_a = ram_wdata;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0; en_extra = 1'b0;
    do begin
      @(negedge clk);
      lat++;
      if (ram_en) en_extra = 1'b1;
    end while (!rsp_valid && lat < 20);
    rd = rsp_rdata; er = rsp_err;
  endtask

  // Transaction checked fully against the reference model.
  task automatic checked(input string nm, input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd);
    logic [31:0] rd, e_rd, wd_a, e_wl;
    logic er, e_er, en_a, e_en, en_x;
    logic [3:0] we_a, e_wm;
    logic [9:0] addr_a;
    int lat, e_lat;
    ref_access(we, sz, uns, addr, wd, e_rd, e_er, e_en, e_wm, e_wl);
    xfer(we, sz, uns, addr, wd, rd, er, lat, en_a, we_a, addr_a, wd_a, en_x);
    e_lat = (e_en && !we) ? 2 : 1;
    total++; if (er !== e_er) begin bad++; $display("FAIL %s_err got=%0b exp=%0b addr=%h", nm, er, e_er, addr); end
    total++; if (rd !== e_rd) begin bad++; $display("FAIL %s_rdata got=%h exp=%h addr=%h", nm, rd, e_rd, addr); end
    total++; if (lat != e_lat) begin bad++; $display("FAIL %s_latency got=%0d exp=%0d", nm, lat, e_lat); end
    total++; if (en_a !== e_en) begin bad++; $display("FAIL %s_ram_en got=%0b exp=%0b addr=%h", nm, en_a, e_en, addr); end
    total++; if (en_x !== 1'b0) begin bad++; $display("FAIL %s_ram_en_late got=%0b exp=0", nm, en_x); end
    if (e_en) begin
      total++; if (we_a !== e_wm) begin bad++; $display("FAIL %s_ram_we got=%b exp=%b", nm, we_a, e_wm); end
      total++; if (addr_a !== addr[11:2]) begin bad++; $display("FAIL %s_ram_addr got=%h exp=%h", nm, addr_a, addr[11:2]); end
      total++; if ((wd_a & lane_bits(e_wm)) !== e_wl) begin bad++; $display("FAIL %s_ram_wdata got=%h exp=%h", nm, wd_a & lane_bits(e_wm), e_wl); end
    end
  endtask

  // GPIO word access; only response fields are checked.
  task automatic gpio_acc(input string nm, input logic we, input logic [1:0] sz,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] e_rd, input logic e_er);
    logic [31:0] rd, wd_a;
    logic er, en_a, en_x;
    logic [3:0] we_a;
    logic [9:0] addr_a;
    int lat;
    xfer(we, sz, 1'b0, addr, wd, rd, er, lat, en_a, we_a, addr_a, wd_a, en_x);
    total++; if (er !== e_er) begin bad++; $display("FAIL %s_err got=%0b exp=%0b", nm, er, e_er); end
    total++; if (rd !== e_rd) begin bad++; $display("FAIL %s_rdata got=%h exp=%h", nm, rd, e_rd); end
    total++; if (lat != 1) begin bad++; $display("FAIL %s_latency got=%0d exp=1", nm, lat); end
    total++; if (en_a !== 1'b0) begin bad++; $display("FAIL %s_ram_en got=%0b exp=0", nm, en_a); end
  endtask

  task automatic test_reset();
    i_rst = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%0b exp=0", rsp_valid); end
    total++; if (rsp_rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", rsp_rdata); end
    total++; if (rsp_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%0b exp=0", rsp_err); end
    i_rst = 1'b1;
    @(negedge clk);
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready got=%0b exp=1", req_ready); end
    total++; if (ram_en !== 1'b0) begin bad++; $display("FAIL reset_ram_en got=%0b exp=0", ram_en); end
  endtask

  task automatic test_init_ram();
    for (int w = 0; w < 16; w++) checked("init", 1'b1, 2'd2, 1'b0, 32'(w * 4), $urandom);
  endtask

  task automatic test_word();
    checked("word_st", 1'b1, 2'd2, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF);
    checked("word_ld", 1'b0, 2'd2, 1'b0, 32'h0000_0010, 32'h0);
  endtask

  task automatic test_byte();
    checked("byte_st", 1'b1, 2'd0, 1'b0, 32'h0000_0013, 32'h0000_0080);
    checked("byte_lds", 1'b0, 2'd0, 1'b0, 32'h0000_0013, 32'h0);
    checked("byte_ldu", 1'b0, 2'd0, 1'b1, 32'h0000_0013, 32'h0);
    checked("half_lds", 1'b0, 2'd1, 1'b0, 32'h0000_0012, 32'h0);
  endtask

  task automatic test_errors();
    checked("mis_half", 1'b0, 2'd1, 1'b0, 32'h0000_0001, 32'h0);
    checked("mis_word", 1'b1, 2'd2, 1'b0, 32'h0000_0006, 32'h1234_5678);
    checked("size3", 1'b1, 2'd3, 1'b0, 32'h0000_0008, 32'h1111_1111);
    checked("unmapped", 1'b1, 2'd2, 1'b0, 32'h2000_0000, 32'h2222_2222);
    checked("after_err", 1'b0, 2'd2, 1'b0, 32'h0000_0004, 32'h0);
    gpio_acc("gpio_byte", 1'b0, 2'd0, 32'h4000_0000, 32'h0, 32'h0, 1'b1);
    gpio_acc("gpio_gap", 1'b1, 2'd2, 32'h4000_000C, 32'h5, 32'h0, 1'b1);
  endtask

  task automatic test_gpio();
    logic [7:0] pins;
    gpio_acc("dir_wr", 1'b1, 2'd2, 32'h4000_0004, 32'h0000_00FF, 32'h0, 1'b0);
    gpio_acc("out_wr", 1'b1, 2'd2, 32'h4000_0000, 32'h0000_00A5, 32'h0, 1'b0);
    ext_en = 32'hFFFF_FF00; ext_val = 32'h0000_3C00;
    repeat (3) @(negedge clk);
    pins = gpio_w[7:0];
    total++; if (pins !== 8'hA5) begin bad++; $display("FAIL gpio_pins got=%h exp=a5", pins); end
    gpio_acc("in_rd", 1'b0, 2'd2, 32'h4000_0008, 32'h0, 32'h0000_3CA5, 1'b0);
    gpio_acc("out_rd", 1'b0, 2'd2, 32'h4000_0000, 32'h0, 32'h0000_00A5, 1'b0);
    gpio_acc("dir_rd", 1'b0, 2'd2, 32'h4000_0004, 32'h0, 32'h0000_00FF, 1'b0);
    gpio_acc("in_wr", 1'b1, 2'd2, 32'h4000_0008, 32'hFFFF_FFFF, 32'h0, 1'b0);
    gpio_acc("out_rd2", 1'b0, 2'd2, 32'h4000_0000, 32'h0, 32'h0000_00A5, 1'b0);
  endtask

  task automatic test_stall();
    logic [31:0] e_rd, e_wl, wd2;
    logic e_er, e_en;
    logic [3:0] e_wm;
    int n;
    ref_access(1'b0, 2'd2, 1'b0, 32'h0000_0020, 32'h0, e_rd, e_er, e_en, e_wm, e_wl);
    wd2 = $urandom;
    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_uns = 1'b0;
    req_addr = 32'h0000_0020; req_wdata = 32'h0;
    @(posedge clk); #1;
    req_we = 1'b1; req_addr = 32'h0000_0024; req_wdata = wd2;
    n = 0;
    do begin @(negedge clk); n++; end while (!rsp_valid && n < 10);
    for (int c = 0; c < 5; c++) begin
      total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL stall_valid c=%0d got=%0b exp=1", c, rsp_valid); end
      total++; if (rsp_rdata !== e_rd) begin bad++; $display("FAIL stall_rdata c=%0d got=%h exp=%h", c, rsp_rdata, e_rd); end
      total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL stall_req_ready c=%0d got=%0b exp=0", c, req_ready); end
      total++; if (ram_en !== 1'b0) begin bad++; $display("FAIL stall_ram_en c=%0d got=%0b exp=0", c, ram_en); end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL stall_release got=%0b exp=0", rsp_valid); end
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL stall_next_ready got=%0b exp=1", req_ready); end
    total++; if (ram_en !== 1'b1) begin bad++; $display("FAIL stall_next_en got=%0b exp=1", ram_en); end
    ref_access(1'b1, 2'd2, 1'b0, 32'h0000_0024, wd2, e_rd, e_er, e_en, e_wm, e_wl);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    total++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0) begin bad++; $display("FAIL stall_store_rsp got=%0b%0b exp=10", rsp_valid, rsp_err); end
    checked("stall_chk", 1'b0, 2'd2, 1'b0, 32'h0000_0024, 32'h0);
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [1:0] sz;
    for (int t = 0; t < 250; t++) begin
      sz = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) a = {4'($urandom_range(5, 15)), 28'($urandom)};
      else a = {4'h0, 16'($urandom), 12'($urandom_range(0, 63))};
      checked("rand", 1'($urandom), sz, 1'($urandom), a, $urandom);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] ev;
    gpio_acc("rm_dir", 1'b1, 2'd2, 32'h4000_0004, 32'h0000_00FF, 32'h0, 1'b0);
    gpio_acc("rm_out", 1'b1, 2'd2, 32'h4000_0000, 32'h0000_005A, 32'h0, 1'b0);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_uns = 1'b0;
    req_addr = 32'h0000_0008; req_wdata = 32'h0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    #1 i_rst = 1'b0;
    #1;
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rmid_valid got=%0b exp=0", rsp_valid); end
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rmid_ready got=%0b exp=1", req_ready); end
    @(posedge clk);
    @(negedge clk);
    i_rst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rmid_stale c=%0d got=%0b exp=0", c, rsp_valid); end
    end
    ev = $urandom;
    ext_en = 32'hFFFF_FFFF; ext_val = ev;
    repeat (3) @(negedge clk);
    gpio_acc("rm_dir_rd", 1'b0, 2'd2, 32'h4000_0004, 32'h0, 32'h0, 1'b0);
    gpio_acc("rm_out_rd", 1'b0, 2'd2, 32'h4000_0000, 32'h0, 32'h0, 1'b0);
    gpio_acc("rm_in_rd", 1'b0, 2'd2, 32'h4000_0008, 32'h0, ev, 1'b0);
  endtask

  initial begin
    total = 0; bad = 0;
    for (int i = 0; i < 4096; i++) ref_mem[i] = 8'h00;
    i_rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_uns = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0; rsp_ready = 1'b1;
    ext_en = 32'h0; ext_val = 32'h0;
    test_reset();
    test_init_ram();
    test_word();
    test_byte();
    test_errors();
    test_gpio();
    test_stall();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
